// File: rtl/if_fetch_stage.sv
// Instruction-fetch stage: program counter, a single-outstanding
// instruction-memory request FSM with a one-entry skid buffer, and the
// IF/ID pipeline register. Stalls, flushes and redirects from hazard
// control are all resolved here, so decode only ever sees {pc, instr, valid}.
module if_fetch_stage #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        pc_write,
    input  logic        IF_ID_reg_write,
    input  logic        instr_flush,
    input  logic [1:0]  branch_sel,
    input  logic [31:0] EXE_pc_imm,
    input  logic [31:0] EXE_jalr_tgt,
    input  logic [31:0] csr_vec,
    output logic        im_req,
    output logic [31:0] im_addr,
    input  logic        im_rvalid,
    input  logic [31:0] im_rdata,
    output logic [31:0] ID_pc,
    output logic [31:0] ID_instr,
    output logic        ID_valid
);

    // Fetch FSM encoding
    localparam logic [1:0] ST_IDLE = 2'b00;
    localparam logic [1:0] ST_REQ  = 2'b01;
    localparam logic [1:0] ST_WAIT = 2'b10;
    localparam logic [1:0] ST_HOLD = 2'b11;

    // Architectural / pipeline state
    logic [1:0]  state_reg,    state_next;
    logic [31:0] pc_reg,       pc_next;
    logic        kill_reg,     kill_next;
    logic [31:0] skid_reg,     skid_next;
    logic [31:0] id_pc_reg,    id_pc_next;
    logic [31:0] id_instr_reg, id_instr_next;
    logic        id_valid_reg, id_valid_next;

    // Decoded control
    logic        redirect;
    logic        accept;
    logic        in_wait;
    logic        in_hold;
    logic        mem_return;
    logic        take_mem;
    logic        take_skid;
    logic        deliver;
    logic [31:0] deliver_instr;
    logic [31:0] pc_plus4;
    logic [31:0] redirect_tgt;

    // Candidate next-PC sources indexed directly by branch_sel
    logic [31:0] tgt_raw     [4];
    logic [31:0] tgt_aligned [4];

    assign pc_plus4   = pc_reg + 32'd4;    // wraps naturally modulo 2^32
    assign tgt_raw[0] = pc_plus4;
    assign tgt_raw[1] = EXE_pc_imm;
    assign tgt_raw[2] = EXE_jalr_tgt;
    assign tgt_raw[3] = csr_vec;

    // Every fetch target is word aligned: bits [1:0] are forced to zero
    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_tgt_align
            assign tgt_aligned[gi] = tgt_raw[gi] & 32'hFFFF_FFFC;
        end
    endgenerate

    assign redirect_tgt = tgt_aligned[branch_sel];

    assign redirect   = (branch_sel != 2'b00);
    assign accept     = pc_write & IF_ID_reg_write;
    assign in_wait    = (state_reg == ST_WAIT);
    assign in_hold    = (state_reg == ST_HOLD);

    // Returns are only meaningful while a request is outstanding
    assign mem_return = in_wait & im_rvalid;

    // A live instruction reaches IF/ID either straight from memory or from
    // the skid buffer; a redirect or a killed request suppresses both.
    assign take_mem      = mem_return & ~kill_reg & ~redirect & accept;
    assign take_skid     = in_hold & ~redirect & accept;
    assign deliver       = take_mem | take_skid;
    assign deliver_instr = take_skid ? skid_reg : im_rdata;

    // Memory request interface is a pure decode of the FSM and PC
    assign im_req  = (state_reg == ST_REQ);
    assign im_addr = pc_reg;

    // Fetch FSM next-state, kill flag and skid-buffer capture
    always_comb begin
        state_next = state_reg;
        kill_next  = kill_reg;
        skid_next  = skid_reg;
        case (state_reg)
            ST_IDLE: begin
                state_next = ST_REQ;
            end
            ST_REQ: begin
                state_next = ST_WAIT;
                // Request already left with the old PC; its data must be dropped
                if (redirect) begin
                    kill_next = 1'b1;
                end
            end
            ST_WAIT: begin
                if (im_rvalid) begin
                    if (kill_reg || redirect) begin
                        kill_next  = 1'b0;
                        state_next = ST_REQ;
                    end else if (accept) begin
                        state_next = ST_REQ;
                    end else begin
                        skid_next  = im_rdata;
                        state_next = ST_HOLD;
                    end
                end else if (redirect) begin
                    kill_next = 1'b1;
                end
            end
            ST_HOLD: begin
                // Redirect discards the buffered word by simply leaving HOLD
                if (redirect || accept) begin
                    state_next = ST_REQ;
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // PC: redirect beats stall, stall beats sequential advance
    always_comb begin
        pc_next = pc_reg;
        if (redirect) begin
            pc_next = redirect_tgt;
        end else if (!pc_write) begin
            pc_next = pc_reg;
        end else if (deliver) begin
            pc_next = pc_plus4;
        end
    end

    // IF/ID: flush/redirect bubble > hold > load > bubble while waiting
    always_comb begin
        id_pc_next    = id_pc_reg;
        id_instr_next = id_instr_reg;
        id_valid_next = id_valid_reg;
        if (instr_flush || redirect) begin
            id_instr_next = NOP_INSTR;
            id_valid_next = 1'b0;
        end else if (!IF_ID_reg_write) begin
            id_pc_next    = id_pc_reg;
        end else if (deliver) begin
            id_pc_next    = pc_reg;
            id_instr_next = deliver_instr;
            id_valid_next = 1'b1;
        end else begin
            id_instr_next = NOP_INSTR;
            id_valid_next = 1'b0;
        end
    end

    // Fetch control state; reset drops any in-flight request bookkeeping
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= ST_IDLE;
            pc_reg    <= RESET_PC;
            kill_reg  <= 1'b0;
            skid_reg  <= 32'h0000_0000;
        end else begin
            state_reg <= state_next;
            pc_reg    <= pc_next;
            kill_reg  <= kill_next;
            skid_reg  <= skid_next;
        end
    end

    // IF/ID pipeline register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            id_pc_reg    <= 32'h0000_0000;
            id_instr_reg <= NOP_INSTR;
            id_valid_reg <= 1'b0;
        end else begin
            id_pc_reg    <= id_pc_next;
            id_instr_reg <= id_instr_next;
            id_valid_reg <= id_valid_next;
        end
    end

    assign ID_pc    = id_pc_reg;
    assign ID_instr = id_instr_reg;
    assign ID_valid = id_valid_reg;

endmodule

// File: tb/tb_if_fetch_stage.sv
// Self-checking bench for if_fetch_stage: directed scenarios plus a
// randomized run against a flag/queue reference model of the fetch unit.
module tb_if_fetch_stage;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        pc_write = 1'b1;
    logic        if_id_we = 1'b1;
    logic        instr_flush = 1'b0;
    logic [1:0]  branch_sel = 2'b00;
    logic [31:0] exe_pc_imm = 32'h0;
    logic [31:0] exe_jalr_tgt = 32'h0;
    logic [31:0] csr_vec = 32'h0;
    logic        im_rvalid = 1'b0;
    logic [31:0] im_rdata = 32'h0;

    logic        im_req, w_im_req;
    logic [31:0] im_addr, w_im_addr;
    logic [31:0] id_pc, w_id_pc;
    logic [31:0] id_instr, w_id_instr;
    logic        id_valid, w_id_valid;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    if_fetch_stage u_dut (
        .clk(clk), .rst_n(rst_n), .pc_write(pc_write), .IF_ID_reg_write(if_id_we),
        .instr_flush(instr_flush), .branch_sel(branch_sel), .EXE_pc_imm(exe_pc_imm),
        .EXE_jalr_tgt(exe_jalr_tgt), .csr_vec(csr_vec), .im_req(im_req), .im_addr(im_addr),
        .im_rvalid(im_rvalid), .im_rdata(im_rdata), .ID_pc(id_pc), .ID_instr(id_instr),
        .ID_valid(id_valid)
    );

    if_fetch_stage #(.RESET_PC(32'hFFFF_FFFC)) u_wrap (
        .clk(clk), .rst_n(rst_n), .pc_write(pc_write), .IF_ID_reg_write(if_id_we),
        .instr_flush(instr_flush), .branch_sel(branch_sel), .EXE_pc_imm(exe_pc_imm),
        .EXE_jalr_tgt(exe_jalr_tgt), .csr_vec(csr_vec), .im_req(w_im_req), .im_addr(w_im_addr),
        .im_rvalid(im_rvalid), .im_rdata(im_rdata), .ID_pc(w_id_pc), .ID_instr(w_id_instr),
        .ID_valid(w_id_valid)
    );

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0], ~a[15:0]} ^ 32'h0F0F_3C3C;
    endfunction

    task automatic set_defaults();
        pc_write = 1'b1; if_id_we = 1'b1; instr_flush = 1'b0; branch_sel = 2'b00;
        im_rvalid = 1'b0; im_rdata = 32'h0;
    endtask

    // Leaves the bench at the negedge where rst_n was released (DUT in IDLE)
    task automatic apply_reset();
        @(negedge clk);
        rst_n = 1'b0;
        set_defaults();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        @(negedge clk);
        checks++; if (im_req !== 1'b0) begin errors++; $display("FAIL rst_req got %0b exp 0", im_req); end
        checks++; if (id_pc !== 32'h0) begin errors++; $display("FAIL rst_id_pc got %h exp 0", id_pc); end
        checks++; if (id_instr !== NOP) begin errors++; $display("FAIL rst_id_instr got %h exp %h", id_instr, NOP); end
        checks++; if (id_valid !== 1'b0) begin errors++; $display("FAIL rst_id_valid got %0b exp 0", id_valid); end
        rst_n = 1'b1;
        @(negedge clk);
        checks++; if (im_req !== 1'b1) begin errors++; $display("FAIL rst_first_req got %0b exp 1", im_req); end
        checks++; if (im_addr !== 32'h0) begin errors++; $display("FAIL rst_first_addr got %h exp 0", im_addr); end
    endtask

    // Latency-1 memory, always accepting: one instruction every two cycles
    task automatic test_stream();
        logic [31:0] d;
        apply_reset();
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            im_rvalid = 1'b0;
            checks++; if (im_req !== 1'b1) begin errors++; $display("FAIL stream_req k=%0d got %0b exp 1", k, im_req); end
            checks++; if (im_addr !== 32'(4 * k)) begin errors++; $display("FAIL stream_addr k=%0d got %h exp %h", k, im_addr, 32'(4 * k)); end
            if (k > 0) begin
                d = 32'h1000_0000 + 32'(k - 1);
                checks++; if (id_valid !== 1'b1) begin errors++; $display("FAIL stream_valid k=%0d got %0b exp 1", k, id_valid); end
                checks++; if (id_pc !== 32'(4 * (k - 1))) begin errors++; $display("FAIL stream_pc k=%0d got %h exp %h", k, id_pc, 32'(4 * (k - 1))); end
                checks++; if (id_instr !== d) begin errors++; $display("FAIL stream_instr k=%0d got %h exp %h", k, id_instr, d); end
            end
            @(negedge clk);
            checks++; if (im_req !== 1'b0) begin errors++; $display("FAIL stream_wait_req k=%0d got %0b exp 0", k, im_req); end
            checks++; if (id_valid !== 1'b0) begin errors++; $display("FAIL stream_bubble k=%0d got %0b exp 0", k, id_valid); end
            if (k < 3) begin
                im_rvalid = 1'b1;
                im_rdata  = 32'h1000_0000 + 32'(k);
            end
        end
        set_defaults();
    endtask

    // Stall while data returns: word parks in the skid buffer, IF/ID holds
    task automatic test_stall_hold();
        apply_reset();
        @(negedge clk);                                   // REQ addr 0
        @(negedge clk); im_rvalid = 1'b1; im_rdata = 32'h1234_5678;
        @(negedge clk); im_rvalid = 1'b0;                 // REQ addr 4, ID holds D0
        pc_write = 1'b0; if_id_we = 1'b0;
        @(negedge clk); im_rvalid = 1'b1; im_rdata = 32'hAAAA_0001;
        for (int k = 0; k < 2; k++) begin
            @(negedge clk); im_rvalid = 1'b0;
            checks++; if (im_req !== 1'b0) begin errors++; $display("FAIL hold_req k=%0d got %0b exp 0", k, im_req); end
            checks++; if (id_valid !== 1'b1) begin errors++; $display("FAIL hold_valid k=%0d got %0b exp 1", k, id_valid); end
            checks++; if (id_instr !== 32'h1234_5678) begin errors++; $display("FAIL hold_instr k=%0d got %h exp 12345678", k, id_instr); end
        end
        pc_write = 1'b1; if_id_we = 1'b1;
        @(negedge clk);
        checks++; if (id_instr !== 32'hAAAA_0001) begin errors++; $display("FAIL release_instr got %h exp aaaa0001", id_instr); end
        checks++; if (id_pc !== 32'h4) begin errors++; $display("FAIL release_pc got %h exp 4", id_pc); end
        checks++; if (id_valid !== 1'b1) begin errors++; $display("FAIL release_valid got %0b exp 1", id_valid); end
        checks++; if (im_req !== 1'b1 || im_addr !== 32'h8) begin errors++; $display("FAIL release_next_addr got req=%0b addr=%h exp req=1 addr=8", im_req, im_addr); end
        set_defaults();
    endtask

    // Redirect during a 3-cycle WAIT: stale data dropped, refetch from target
    task automatic test_redirect_wait();
        apply_reset();
        @(negedge clk);                                   // REQ addr 0
        @(negedge clk); branch_sel = 2'b01; exe_pc_imm = 32'h0000_0103;
        @(negedge clk); branch_sel = 2'b00;
        checks++; if (id_valid !== 1'b0) begin errors++; $display("FAIL redir_valid_a got %0b exp 0", id_valid); end
        @(negedge clk); im_rvalid = 1'b1; im_rdata = 32'hDEAD_BEEF;
        checks++; if (im_req !== 1'b0) begin errors++; $display("FAIL redir_noreq got %0b exp 0", im_req); end
        @(negedge clk); im_rvalid = 1'b0;
        checks++; if (id_valid !== 1'b0) begin errors++; $display("FAIL redir_drop_valid got %0b exp 0", id_valid); end
        checks++; if (im_req !== 1'b1 || im_addr !== 32'h0000_0100) begin errors++; $display("FAIL redir_addr got req=%0b addr=%h exp req=1 addr=00000100", im_req, im_addr); end
        @(negedge clk); im_rvalid = 1'b1; im_rdata = 32'h0BAD_F00D;
        @(negedge clk); im_rvalid = 1'b0;
        checks++; if (id_valid !== 1'b1 || id_instr !== 32'h0BAD_F00D || id_pc !== 32'h100) begin errors++; $display("FAIL redir_new got v=%0b i=%h pc=%h exp v=1 i=0badf00d pc=100", id_valid, id_instr, id_pc); end
        set_defaults();
    endtask

    // jalr redirect coinciding with a return and an IF/ID stall
    task automatic test_redirect_rvalid();
        apply_reset();
        @(negedge clk);
        @(negedge clk); im_rvalid = 1'b1; im_rdata = 32'h5555_0000;
        @(negedge clk); im_rvalid = 1'b0;                 // ID holds {0,5555_0000,1}
        @(negedge clk);
        im_rvalid = 1'b1; im_rdata = 32'hBEEF_0001;
        branch_sel = 2'b10; exe_jalr_tgt = 32'h0000_2223; if_id_we = 1'b0;
        @(negedge clk); set_defaults();
        checks++; if (id_instr !== NOP || id_valid !== 1'b0) begin errors++; $display("FAIL jalr_bubble got i=%h v=%0b exp i=%h v=0", id_instr, id_valid, NOP); end
        checks++; if (id_pc !== 32'h0) begin errors++; $display("FAIL jalr_id_pc got %h exp 0", id_pc); end
        checks++; if (im_req !== 1'b1 || im_addr !== 32'h0000_2220) begin errors++; $display("FAIL jalr_addr got req=%0b addr=%h exp req=1 addr=00002220", im_req, im_addr); end
    endtask

    // Flush with no redirect: IF/ID bubbles, fetch carries on sequentially
    task automatic test_flush();
        apply_reset();
        @(negedge clk);
        @(negedge clk); im_rvalid = 1'b1; im_rdata = 32'h7777_0000; instr_flush = 1'b1;
        @(negedge clk); set_defaults();
        checks++; if (id_valid !== 1'b0 || id_instr !== NOP) begin errors++; $display("FAIL flush_bubble got v=%0b i=%h exp v=0 i=%h", id_valid, id_instr, NOP); end
        checks++; if (im_req !== 1'b1 || im_addr !== 32'h4) begin errors++; $display("FAIL flush_pc got req=%0b addr=%h exp req=1 addr=4", im_req, im_addr); end
    endtask

    task automatic test_pc_wrap();
        apply_reset();
        @(negedge clk);
        checks++; if (w_im_req !== 1'b1 || w_im_addr !== 32'hFFFF_FFFC) begin errors++; $display("FAIL wrap_first got req=%0b addr=%h exp req=1 addr=fffffffc", w_im_req, w_im_addr); end
        @(negedge clk); im_rvalid = 1'b1; im_rdata = 32'h0000_1111;
        @(negedge clk); im_rvalid = 1'b0;
        checks++; if (w_im_req !== 1'b1 || w_im_addr !== 32'h0) begin errors++; $display("FAIL wrap_second got req=%0b addr=%h exp req=1 addr=0", w_im_req, w_im_addr); end
        checks++; if (w_id_pc !== 32'hFFFF_FFFC || w_id_valid !== 1'b1) begin errors++; $display("FAIL wrap_id got pc=%h v=%0b exp pc=fffffffc v=1", w_id_pc, w_id_valid); end
    endtask

    // Async reset mid-WAIT, late return afterwards must be ignored
    task automatic test_reset_mid_wait();
        apply_reset();
        @(negedge clk);
        @(negedge clk); im_rvalid = 1'b1; im_rdata = 32'h1111_0000;
        @(negedge clk); im_rvalid = 1'b0;
        @(negedge clk); im_rvalid = 1'b1; im_rdata = 32'h2222_0000;
        @(negedge clk); im_rvalid = 1'b0; if_id_we = 1'b0;   // ID={4,2222_0000,1}, REQ addr 8
        @(negedge clk);                                      // WAIT for addr 8
        #2 rst_n = 1'b0;
        #1;
        checks++; if (im_req !== 1'b0) begin errors++; $display("FAIL mrst_req got %0b exp 0", im_req); end
        checks++; if (id_pc !== 32'h0 || id_instr !== NOP || id_valid !== 1'b0) begin errors++; $display("FAIL mrst_id got pc=%h i=%h v=%0b exp pc=0 i=%h v=0", id_pc, id_instr, id_valid, NOP); end
        @(negedge clk);
        rst_n = 1'b1; if_id_we = 1'b1; im_rvalid = 1'b1; im_rdata = 32'hBAD0_0BAD;
        @(negedge clk);
        checks++; if (im_req !== 1'b1 || im_addr !== 32'h0) begin errors++; $display("FAIL mrst_first got req=%0b addr=%h exp req=1 addr=0", im_req, im_addr); end
        checks++; if (id_valid !== 1'b0) begin errors++; $display("FAIL mrst_late got %0b exp 0", id_valid); end
        @(negedge clk); im_rdata = 32'h3333_0000;
        @(negedge clk); im_rvalid = 1'b0;
        checks++; if (id_valid !== 1'b1 || id_instr !== 32'h3333_0000 || id_pc !== 32'h0) begin errors++; $display("FAIL mrst_refetch got v=%0b i=%h pc=%h exp v=1 i=33330000 pc=0", id_valid, id_instr, id_pc); end
        set_defaults();
    endtask

    // Random hazards and variable-latency memory against a reference model
    task automatic test_random();
        logic [31:0] m_pc, m_id_pc, m_id_instr, tgt, word;
        logic        m_id_valid, m_boot, m_req_due, m_in_flight, m_stale;
        logic        redir, acc, arrive, got, nreq;
        logic [31:0] m_held[$];
        logic        mem_pend;
        int          mem_cnt;
        logic [31:0] mem_addr;
        apply_reset();
        m_pc = 32'h0; m_id_pc = 32'h0; m_id_instr = NOP; m_id_valid = 1'b0;
        m_boot = 1'b1; m_req_due = 1'b0; m_in_flight = 1'b0; m_stale = 1'b0;
        m_held.delete();
        mem_pend = 1'b0; mem_cnt = 0; mem_addr = 32'h0;
        word = 32'h0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            checks++; if (im_req !== m_req_due) begin errors++; $display("FAIL rnd_req cyc=%0d got %0b exp %0b", cyc, im_req, m_req_due); end
            if (m_req_due) begin
                checks++; if (im_addr !== m_pc) begin errors++; $display("FAIL rnd_addr cyc=%0d got %h exp %h", cyc, im_addr, m_pc); end
            end
            checks++; if (id_valid !== m_id_valid) begin errors++; $display("FAIL rnd_valid cyc=%0d got %0b exp %0b", cyc, id_valid, m_id_valid); end
            checks++; if (id_instr !== m_id_instr) begin errors++; $display("FAIL rnd_instr cyc=%0d got %h exp %h", cyc, id_instr, m_id_instr); end
            checks++; if (id_pc !== m_id_pc) begin errors++; $display("FAIL rnd_pc cyc=%0d got %h exp %h", cyc, id_pc, m_id_pc); end

            // memory responder: one pending request, latency 1..3, rare spurious strobes
            im_rvalid = 1'b0; im_rdata = $urandom;
            if (mem_pend) begin
                if (mem_cnt == 1) begin
                    im_rvalid = 1'b1; im_rdata = mem_word(mem_addr); mem_pend = 1'b0;
                end else begin
                    mem_cnt--;
                end
            end else if ($urandom_range(0, 19) == 0) begin
                im_rvalid = 1'b1;
            end
            if (im_req) begin
                mem_pend = 1'b1; mem_cnt = int'($urandom_range(1, 3)); mem_addr = im_addr;
            end

            // hazard-control stimulus
            pc_write     = ($urandom_range(0, 3) != 0);
            if_id_we     = ($urandom_range(0, 3) != 0);
            instr_flush  = ($urandom_range(0, 19) == 0);
            branch_sel   = ($urandom_range(0, 9) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
            exe_pc_imm   = $urandom;
            exe_jalr_tgt = $urandom;
            csr_vec      = $urandom;

            // reference model for this clock edge
            redir = (branch_sel != 2'b00);
            acc   = pc_write & if_id_we;
            case (branch_sel)
                2'b01:   tgt = exe_pc_imm;
                2'b10:   tgt = exe_jalr_tgt;
                2'b11:   tgt = csr_vec;
                default: tgt = m_pc;
            endcase
            tgt    = tgt & 32'hFFFF_FFFC;
            arrive = m_in_flight & im_rvalid;
            got    = 1'b0;
            if (!redir && acc) begin
                if (m_held.size() != 0) begin
                    got = 1'b1; word = m_held[0];
                end else if (arrive && !m_stale) begin
                    got = 1'b1; word = im_rdata;
                end
            end
            if (instr_flush || redir) begin
                m_id_instr = NOP; m_id_valid = 1'b0;
            end else if (!if_id_we) begin
                m_id_valid = m_id_valid;
            end else if (got) begin
                m_id_pc = m_pc; m_id_instr = word; m_id_valid = 1'b1;
            end else begin
                m_id_instr = NOP; m_id_valid = 1'b0;
            end
            nreq = 1'b0;
            if (m_boot) begin
                m_boot = 1'b0; nreq = 1'b1;
            end else if (m_req_due) begin
                m_in_flight = 1'b1; m_stale = redir;
            end else if (arrive) begin
                m_in_flight = 1'b0;
                if (m_stale || redir) begin
                    m_stale = 1'b0; nreq = 1'b1;
                end else if (got) begin
                    nreq = 1'b1;
                end else begin
                    m_held.push_back(im_rdata);
                end
            end else if (m_in_flight) begin
                if (redir) m_stale = 1'b1;
            end else if (m_held.size() != 0) begin
                if (redir || got) begin
                    m_held.delete(); nreq = 1'b1;
                end
            end
            m_req_due = nreq;
            if (redir) m_pc = tgt;
            else if (pc_write && got) m_pc = m_pc + 32'd4;

            @(negedge clk);
        end
        set_defaults();
    endtask

    initial begin
        test_reset();
        test_stream();
        test_stall_hold();
        test_redirect_wait();
        test_redirect_rvalid();
        test_flush();
        test_pc_wrap();
        test_reset_mid_wait();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog time limit reached checks=%0d errors=%0d", checks, errors);
        $fatal(1);
    end

endmodule
